imem_arbiter: RTL
=================

# imem_arbiter

Arbiter and boot sequencer for the single-port instruction memory. Shares one memory port between the core's instruction-fetch interface (read-only) and a loader/debug interface (read/write). After reset it can hold fetch off until the loader has written the program image. It also enforces word alignment and registers one response per accepted request.

## Interface
Parameters:
- `STARVE_MAX`, default 4: consecutive denied loader cycles in RUN before the loader gets priority; legal range 1..15.
- `BOOT_HOLD`, default 1: 1 = start in BOOT (fetch blocked until `ld_done`); 0 = start in RUN.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `if_req` in 1: fetch request.
- `if_addr` in 32: fetch byte address.
- `if_gnt` out 1: fetch request accepted this cycle (combinational).
- `if_rvalid` out 1: fetch response valid, one-cycle pulse.
- `if_rdata` out 32: fetch read data.
- `if_err` out 1: fetch response is a misalignment error.
- `ld_req` in 1: loader request.
- `ld_we` in 1: loader write (1) or read (0).
- `ld_addr` in 32: loader byte address.
- `ld_wdata` in 32: loader write data.
- `ld_done` in 1: loader finished image; ends BOOT.
- `ld_gnt` out 1: loader request accepted this cycle (combinational).
- `ld_rvalid` out 1: loader response valid, one-cycle pulse.
- `ld_rdata` out 32: loader read data (0 for writes).
- `ld_err` out 1: loader misalignment error.
- `mem_a` out 32: memory byte address.
- `mem_wd` out 32: memory write data.
- `mem_we` out 1: memory write enable.
- `mem_rd` in 32: memory combinational read data.
- `boot_busy` out 1: high while in BOOT.

## Operation
- **States.** State register is BOOT or RUN.
  - Reset state: BOOT if `BOOT_HOLD`=1, else RUN.
  - BOOT → RUN on any cycle with `ld_done`=1.
  - There is no path back to BOOT except reset.
  - `ld_done` is ignored in RUN.
- **BOOT.** `if_gnt`=0 always. The loader is granted whenever `ld_req`=1.
- **RUN grant rule.**
  - At most one grant per cycle.
  - Fetch has priority by default.
  - Loader wins if `ld_req`=1 and either `if_req`=0 or `starve_cnt`==`STARVE_MAX`.
- **starve_cnt** (4-bit counter):
  - Increments each RUN cycle with `ld_req`=1 and `ld_gnt`=0.
  - Saturates at `STARVE_MAX`.
  - Clears on `ld_gnt`=1.
  - Holds otherwise.
- **Memory mux.** `mem_a` and `mem_wd` follow the granted requester; they follow fetch when nothing is granted. `mem_we` = `ld_gnt` & `ld_we` & (`ld_addr[1:0]`==0).
- **Alignment.** `addr[1:0]`≠0 is still granted, but the request performs no write, and its response carries err=1 with data=0.
- **Response.**
  - Registered on the grant edge; valid the following cycle for exactly one cycle.
  - Reads return `mem_rd` sampled at the grant edge.
  - Writes return rvalid with rdata=0 and err=0.
- **Simultaneous events.**
  - `ld_done` together with a BOOT loader request: the request is served and the state moves to RUN.
  - Fetch held off by a starved loader keeps `if_req` high and is granted next cycle.

## Timing
- Grant is combinational from req/state/`starve_cnt` in the same cycle. The handshake completes on an edge where req & gnt.
- Requesters must hold addr/we/wdata stable while req=1 and gnt=0.
- Latency: grant in cycle N → rvalid/rdata/err in cycle N+1. Back-to-back grants give back-to-back responses.
- Reset values:
  - `if_rvalid`, `ld_rvalid`, `if_err`, `ld_err` = 0.
  - `if_rdata`, `ld_rdata` = 0.
  - `starve_cnt` = 0.
  - `boot_busy` = `BOOT_HOLD`.
  - `mem_we` = 0 (follows from the gnt logic).
- Reset mid-operation: any pending response is dropped (no rvalid after reset deassertion), and the state returns to its reset value.

## Structure
- Shared package `imem_arb_pkg`:
  - state enum (`ST_BOOT`, `ST_RUN`);
  - requester id constants (`REQ_IF`=0, `REQ_LD`=1);
  - `STARVE_W`=4.
- One natural sub-module, `imem_arb_starve_ctr`: the saturating starvation counter, with inputs inc/clr and output at_max.
- The block instantiates alongside the instruction memory. Memory ports connect 1:1 (`mem_a`→address, `mem_wd`→write data, `mem_we`→write enable, `mem_rd`←read data).

## Test plan
- **Boot hold.** `BOOT_HOLD`=1, `if_req`=1 continuously; loader writes 0x00000013 to 0x0, then pulses `ld_done`.
  - Required: `if_gnt`=0 until the cycle after `ld_done`.
  - Then a fetch of 0x0 returns `if_rdata`=0x00000013 one cycle after grant.
- **Write/read round trip in RUN.** Loader writes 0xDEADBEEF to 0x100, then reads 0x100.
  - Write: `ld_rvalid` with `ld_rdata`=0.
  - Read: `ld_rdata`=0xDEADBEEF.
  - `mem_we` high exactly one cycle.
- **Starvation.** `STARVE_MAX`=4; `if_req` and `ld_req` both held high.
  - Required: fetch granted 4 cycles, loader granted on the 5th, then fetch resumes.
  - Pattern repeats every 5 cycles.
- **Misaligned access.** Loader write to 0x102 and fetch from 0x006.
  - Required: no `mem_we`; responses have err=1, rdata=0; memory at 0x100 unchanged.
- **Reset mid-request.** `rst_n` asserted low in the cycle after a grant.
  - Required: `if_rvalid` stays 0; all outputs at reset values.
  - `boot_busy`=1 again when `BOOT_HOLD`=1.
- **Simultaneous `ld_done` with write in BOOT.** Write 0x12345678 to 0x4 in the same cycle as `ld_done`.
  - Required: write lands, `ld_rvalid` next cycle, `boot_busy` drops, and fetch of 0x4 returns 0x12345678.

Source files
------------

// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
//   arb_state_e : arbiter state (boot hold / normal run)
//   REQ_IF/LD   : requester ids used by the memory-port mux
//   STARVE_W    : width of the loader starvation counter
package imem_arb_pkg;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } arb_state_e;

  localparam logic REQ_IF   = 1'b0;
  localparam logic REQ_LD   = 1'b1;
  localparam int   STARVE_W = 4;

  function automatic logic misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/imem_arb_starve_ctr.sv
// Saturating counter of consecutive loader denials.
//   clk, rst_n : clock, async active-low reset
//   inc        : loader requested but was not granted this cycle
//   clr        : loader granted this cycle (wins over inc)
//   at_max     : count has reached MAX, loader must win next arbitration
module imem_arb_starve_ctr
  import imem_arb_pkg::*;
#(
  parameter int unsigned MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam logic [STARVE_W-1:0] MAX_C = STARVE_W'(MAX);

  logic [STARVE_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX_C)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_max = (cnt == MAX_C);

endmodule

// File: rtl/imem_arbiter.sv
// Arbiter and boot sequencer for a single-port instruction memory.
// Fetch (read-only) and loader (read/write) share one port; one grant per
// cycle, response registered on the grant edge and shown for one cycle.
//   clk, rst_n            : clock, async active-low reset
//   if_req/if_addr        : fetch request, byte address
//   if_gnt                : fetch accepted this cycle (combinational)
//   if_rvalid/rdata/err   : fetch response (one-cycle pulse)
//   ld_req/we/addr/wdata  : loader request
//   ld_done               : loader finished the image, leaves BOOT
//   ld_gnt                : loader accepted this cycle (combinational)
//   ld_rvalid/rdata/err   : loader response (one-cycle pulse)
//   mem_a/mem_wd/mem_we   : memory port address, write data, write enable
//   mem_rd                : memory combinational read data
//   boot_busy             : high while fetch is held off in BOOT
//
// state   | meaning
// ST_BOOT | fetch blocked, loader served whenever it asks
// ST_RUN  | fetch has priority, loader wins when idle fetch or starved
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4,
  parameter bit          BOOT_HOLD  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        ld_req,
  input  logic        ld_we,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_wdata,
  input  logic        ld_done,
  output logic        ld_gnt,
  output logic        ld_rvalid,
  output logic [31:0] ld_rdata,
  output logic        ld_err,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd,
  output logic        boot_busy
);

  localparam arb_state_e RST_STATE = BOOT_HOLD ? ST_BOOT : ST_RUN;

  arb_state_e state, state_nxt;
  logic       starved;
  logic       sel;
  logic       if_mis, ld_mis;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RST_STATE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if_gnt    = 1'b0;
    ld_gnt    = 1'b0;
    case (state)
      ST_BOOT: begin
        ld_gnt = ld_req;
        if (ld_done) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        ld_gnt = ld_req && (!if_req || starved);
        if_gnt = if_req && !ld_gnt;
      end
      default: state_nxt = RST_STATE;
    endcase
  end

  // Only denials in RUN count; a BOOT loader request is never denied.
  imem_arb_starve_ctr #(.MAX(STARVE_MAX)) u_starve (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    ((state == ST_RUN) && ld_req && !ld_gnt),
    .clr    (ld_gnt),
    .at_max (starved)
  );

  assign if_mis = misaligned(if_addr);
  assign ld_mis = misaligned(ld_addr);

  assign sel    = ld_gnt ? REQ_LD : REQ_IF;
  assign mem_a  = (sel == REQ_LD) ? ld_addr  : if_addr;
  assign mem_wd = (sel == REQ_LD) ? ld_wdata : 32'h0;
  assign mem_we = ld_gnt && ld_we && !ld_mis;

  assign boot_busy = (state == ST_BOOT);

  // Data regs load only on a grant so they are quiet between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rvalid <= 1'b0;
      if_err    <= 1'b0;
      if_rdata  <= '0;
      ld_rvalid <= 1'b0;
      ld_err    <= 1'b0;
      ld_rdata  <= '0;
    end else begin
      if_rvalid <= if_gnt;
      ld_rvalid <= ld_gnt;
      if (if_gnt) begin
        if_err   <= if_mis;
        if_rdata <= if_mis ? 32'h0 : mem_rd;
      end
      if (ld_gnt) begin
        ld_err   <= ld_mis;
        ld_rdata <= (ld_mis || ld_we) ? 32'h0 : mem_rd;
      end
    end
  end

endmodule
